// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-at-a-time req/ack fetch from imem, holds the instruction for decode; flush redirects.
// Optional IFETCH_MISALIGN_CHK_EN: misaligned PCs bypass memory and deliver a NOP with misalign_o set.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        have_inst_o,
    input  logic        inst_ready_i,
    output logic        pc_en_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_addr;
    logic        misalign_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    logic misalign_q;

    assign misalign_pc = (pc_i[1:0] != 2'b00);
    assign misalign_o  = misalign_q;
`else
    assign misalign_pc = 1'b0;
    assign misalign_o  = 1'b0;
`endif

    assign imem_req_o  = (state == REQ) || (state == DROP);
    assign imem_addr_o = {req_addr[31:2], 2'b00};
    assign have_inst_o = (state == HOLD);
    assign pc_en_o     = have_inst_o & inst_ready_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = misalign_pc ? HOLD : REQ;
            REQ: begin
                if (imem_ack_i) begin
                    state_nxt = flush_i ? IDLE : HOLD;
                end else if (flush_i) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (flush_i || inst_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            // A redirected fetch must still retire the outstanding memory cycle.
            DROP: begin
                if (imem_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr  <= RESET_PC;
            inst_o    <= 32'h0;
            inst_pc_o <= RESET_PC;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_addr <= pc_i;
`ifdef IFETCH_MISALIGN_CHK_EN
                    if (misalign_pc) begin
                        inst_o     <= NOP_INST;
                        inst_pc_o  <= pc_i;
                        misalign_q <= 1'b1;
                    end
`endif
                end
                REQ: begin
                    if (imem_ack_i && !flush_i) begin
                        inst_o    <= imem_rdata_i;
                        inst_pc_o <= req_addr;
`ifdef IFETCH_MISALIGN_CHK_EN
                        misalign_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, corner-case sequences, randomized run vs transaction-level model.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    wire         imem_ack_i;
    wire  [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        have_inst_o;
    logic        inst_ready_i;
    logic        pc_en_o;
    logic        misalign_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    inst_fetch dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .have_inst_o(have_inst_o),
        .inst_ready_i(inst_ready_i), .pc_en_o(pc_en_o), .misalign_o(misalign_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks after mem_lat wait cycles; manual ack override when mem_en is low.
    bit          mem_en = 1'b1;
    bit          man_ack = 1'b0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = 32'h0;

    assign imem_ack_i   = mem_en ? auto_ack : man_ack;
    assign imem_rdata_i = auto_rdata;

    always @(posedge clk_i) begin
        #1;
        auto_ack   = 1'b0;
        auto_rdata = $urandom;
        if (imem_req_o) begin
            if (mem_cnt >= mem_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = mem_word(imem_addr_o);
                mem_cnt    = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          stall;
        logic [31:0] exp_addr;
        int          exp_lat;
        int          exp_req;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[5];

    // Precondition for all sequences below: the DUT is in IDLE during the current cycle.
    task automatic fetch(input vec_t v);
        int n = 0;
        int nreq = 0;
        pc_i = v.pc;
        mem_lat = v.lat;
        inst_ready_i = 1'b0;
        do begin
            @(negedge clk_i);
            n++;
            if (imem_req_o) begin
                nreq++;
                check("req_addr", imem_addr_o, v.exp_addr);
            end
        end while (!have_inst_o && n < 50);
        check("fetch_latency", n, v.exp_lat);
        check("req_cycles", nreq, v.exp_req);
        check("inst", inst_o, v.exp_inst);
        check("inst_pc", inst_pc_o, v.pc);
        check("misalign_clear", misalign_o, 1'b0);
        for (int i = 0; i < v.stall; i++) begin
            #1 check("stall_pc_en", pc_en_o, 1'b0);
            @(negedge clk_i);
            check("stall_have", have_inst_o, 1'b1);
            check("stall_no_req", imem_req_o, 1'b0);
            check("stall_inst", inst_o, v.exp_inst);
            check("stall_inst_pc", inst_pc_o, v.pc);
        end
        inst_ready_i = 1'b1;
        #1 check("pc_en_pulse", pc_en_o, 1'b1);
        @(negedge clk_i);
        inst_ready_i = 1'b0;
        #1 check("pc_en_one_cycle", pc_en_o, 1'b0);
        check("idle_have", have_inst_o, 1'b0);
        check("idle_req", imem_req_o, 1'b0);
    endtask

    task automatic wait_have();
        int n = 0;
        while (!have_inst_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("have_timeout", have_inst_o, 1'b1);
    endtask

    task automatic accept();
        inst_ready_i = 1'b1;
        #1 check("accept_pc_en", pc_en_o, 1'b1);
        @(negedge clk_i);
        inst_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] pc_reg;
        logic [31:0] cur_addr;
        logic        prev_req;
        int          idle_run;
        int          deliveries;

        rst_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0; inst_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_have", have_inst_o, 1'b0);
        check("rst_pc_en", pc_en_o, 1'b0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_misalign", misalign_o, 1'b0);
        inst_ready_i = 1'b0;
        rst_i = 1'b0;

        vecs[0] = '{32'h0000_0000, 0, 0, 32'h0000_0000, 2, 1, 32'h0050_0093};
        vecs[1] = '{32'h0000_0010, 2, 0, 32'h0000_0010, 4, 3, mem_word(32'h10)};
        vecs[2] = '{32'h0000_0024, 0, 5, 32'h0000_0024, 2, 1, mem_word(32'h24)};
        vecs[3] = '{32'h0000_1000, 1, 2, 32'h0000_1000, 3, 2, mem_word(32'h1000)};
        vecs[4] = '{32'hFFFF_FFFC, 3, 1, 32'hFFFF_FFFC, 5, 4, mem_word(32'hFFFF_FFFC)};
        for (int i = 0; i < 5; i++) fetch(vecs[i]);

        // Flush during a waiting request: old address retired, then redirected fetch.
        pc_i = 32'h20; mem_lat = 4;
        @(negedge clk_i);
        check("flreq_req", imem_req_o, 1'b1);
        check("flreq_addr", imem_addr_o, 32'h20);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; pc_i = 32'h40;
        n = 0;
        while (imem_req_o && n < 20) begin
            check("drop_addr", imem_addr_o, 32'h20);
            check("drop_have", have_inst_o, 1'b0);
            @(negedge clk_i);
            n++;
        end
        check("drop_cycles", n, 4);
        check("drop_idle_have", have_inst_o, 1'b0);
        @(negedge clk_i);
        check("redir_req", imem_req_o, 1'b1);
        check("redir_addr", imem_addr_o, 32'h40);
        mem_lat = 0;
        wait_have();
        check("redir_inst_pc", inst_pc_o, 32'h40);
        check("redir_inst", inst_o, mem_word(32'h40));
        accept();

        // Flush coinciding with ack: data discarded, straight back to IDLE.
        pc_i = 32'h50; mem_lat = 0;
        @(negedge clk_i);
        check("flack_ack", imem_ack_i, 1'b1);
        flush_i = 1'b1; pc_i = 32'h60;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flack_have", have_inst_o, 1'b0);
        check("flack_req", imem_req_o, 1'b0);
        @(negedge clk_i);
        check("flack_addr", imem_addr_o, 32'h60);
        wait_have();
        check("flack_inst_pc", inst_pc_o, 32'h60);
        accept();

        // Flush and ready together in HOLD: flush wins.
        pc_i = 32'h70; mem_lat = 0;
        @(negedge clk_i);
        wait_have();
        inst_ready_i = 1'b1; flush_i = 1'b1;
        #1 check("flready_pc_en", pc_en_o, 1'b0);
        @(negedge clk_i);
        inst_ready_i = 1'b0; flush_i = 1'b0;
        check("flready_have", have_inst_o, 1'b0);
        check("flready_req", imem_req_o, 1'b0);

        // Reset mid-request, then a late ack in IDLE.
        pc_i = 32'h80; mem_en = 1'b0; man_ack = 1'b0;
        @(negedge clk_i);
        check("rstreq_req", imem_req_o, 1'b1);
        rst_i = 1'b1;
        #1 check("rstreq_req_drop", imem_req_o, 1'b0);
        check("rstreq_have", have_inst_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0; man_ack = 1'b1;
        @(negedge clk_i);
        man_ack = 1'b0;
        check("late_ack_have", have_inst_o, 1'b0);
        check("late_ack_req", imem_req_o, 1'b1);
        @(negedge clk_i);
        check("late_ack_have2", have_inst_o, 1'b0);
        mem_en = 1'b1; mem_lat = 0;
        wait_have();
        check("rstreq_inst_pc", inst_pc_o, 32'h80);
        accept();

        // Misaligned PC.
        pc_i = 32'h6; mem_lat = 0;
        @(negedge clk_i);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("mis_req", imem_req_o, 1'b0);
        check("mis_have", have_inst_o, 1'b1);
        check("mis_inst", inst_o, 32'h0000_0013);
        check("mis_inst_pc", inst_pc_o, 32'h6);
        check("mis_flag", misalign_o, 1'b1);
`else
        check("mis_req", imem_req_o, 1'b1);
        check("mis_addr", imem_addr_o, 32'h4);
        wait_have();
        check("mis_inst", inst_o, mem_word(32'h4));
        check("mis_flag", misalign_o, 1'b0);
`endif
        accept();

        // Peak rate with ready high and zero-wait memory.
        n = 0; inst_ready_i = 1'b1; pc_i = 32'h300; mem_lat = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (pc_en_o) begin
                n++;
                pc_i = pc_i + 32'h4;
            end
            @(negedge clk_i);
        end
        inst_ready_i = 1'b0;
        check("peak_rate", n, 10);

        // Randomized run: PC register model, each delivery must match the architectural PC.
        pc_reg = 32'h200; pc_i = pc_reg;
        prev_req = 1'b0; cur_addr = 32'h0; idle_run = 0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (imem_req_o) begin
                if (!prev_req) cur_addr = pc_reg & ~32'h3;
                check("rnd_req_addr", imem_addr_o, cur_addr);
            end
            if (have_inst_o) begin
                check("rnd_inst_pc", inst_pc_o, pc_reg);
                check("rnd_inst", inst_o, mem_word(pc_reg));
                check("rnd_misalign", misalign_o, 1'b0);
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (idle_run > 40) begin
                check("rnd_progress", have_inst_o, 1'b1);
                break;
            end
            mem_lat = $urandom_range(0, 3);
            inst_ready_i = ($urandom_range(0, 2) != 0);
            flush_i = (imem_req_o || have_inst_o) && ($urandom_range(0, 9) == 0);
            #1 check("rnd_pc_en", pc_en_o, have_inst_o & inst_ready_i & ~flush_i);
            if (flush_i) begin
                pc_reg = pc_reg + 32'h100 + ($urandom_range(0, 255) << 2);
            end else if (have_inst_o && inst_ready_i) begin
                pc_reg = pc_reg + 32'h4;
                deliveries++;
            end
            pc_i = pc_reg;
            prev_req = imem_req_o;
        end
        @(negedge clk_i);
        flush_i = 1'b0; inst_ready_i = 1'b0;
        check("rnd_throughput", deliveries > 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage for the miniRV-1 multicycle core. It takes the current PC from the PC register and runs a req/ack handshake with instruction memory. It holds the returned instruction and its PC for the decode stage. It also produces the one-cycle advance strobe that lets the PC register load the next PC. Fetch is strictly one-at-a-time, and a branch/jump redirect flushes the stage.

## Interface
- RESET_PC, 32'h0000_0000, value of `req_addr`/`inst_pc_o` after reset
- NOP_INST, 32'h0000_0013, instruction emitted for a misaligned fetch (when checking is enabled)
- clk_i  input  1  core clock; all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- pc_i  input  32  current PC from PC register; must be stable from IDLE until next `pc_en_o`/flush
- flush_i  input  1  redirect pulse; PC register loads target on the same edge
- imem_req_o  output  1  memory request, level
- imem_addr_o  output  32  word address `{req_addr[31:2],2'b00}`
- imem_ack_i  input  1  request complete; `imem_rdata_i` valid this cycle
- imem_rdata_i  input  32  instruction word
- inst_o  output  32  held instruction
- inst_pc_o  output  32  PC of `inst_o`
- have_inst_o  output  1  `inst_o`/`inst_pc_o` valid
- inst_ready_i  input  1  decode accepts the held instruction
- pc_en_o  output  1  `have_inst_o & inst_ready_i & ~flush_i`; PC register advance enable
- misalign_o  output  1  held instruction came from a misaligned PC

## Operation
- **State encoding:** IDLE=2'b00, REQ=2'b01, HOLD=2'b10, DROP=2'b11.
  - `imem_req_o` = state is REQ or DROP.
  - `have_inst_o` = state is HOLD.
- **IDLE:** load `req_addr <= pc_i`, then go to REQ. `flush_i` has no effect in IDLE.
- **REQ:** hold `imem_req_o=1`; `imem_addr_o` stays stable until ack.
  - On `imem_ack_i & ~flush_i`: `inst_o<=imem_rdata_i`, `inst_pc_o<=req_addr`, `misalign_o<=0`, go to HOLD.
  - On `imem_ack_i & flush_i`: discard the data, go to IDLE.
  - On `~imem_ack_i & flush_i`: go to DROP.
- **DROP:** keep the request asserted with the old address until ack. On ack, discard the data and go to IDLE. A further `flush_i` in DROP is absorbed.
- **HOLD:** keep `inst_o`/`inst_pc_o` stable.
  - On `flush_i`, go to IDLE; flush wins over `inst_ready_i`.
  - Otherwise, on `inst_ready_i`, go to IDLE; `pc_en_o` pulses that cycle.
- **Reset values:** state IDLE, `req_addr=RESET_PC`, `inst_o=0`, `inst_pc_o=RESET_PC`, `misalign_o=0`. With reset asserted, `imem_req_o`, `have_inst_o` and `pc_en_o` are all 0.
- **Reset mid-request:** the request is abandoned immediately. A late `imem_ack_i` arriving after reset is ignored, because state is IDLE.
- **`imem_ack_i` outside REQ/DROP:** ignored.

## Timing
- With zero-wait memory (ack in the first REQ cycle), fetch-to-valid is 2 cycles: IDLE at cycle n, REQ at n+1, `have_inst_o` at n+2.
- With `inst_ready_i` held high and zero-wait memory, the peak rate is one instruction per 3 cycles.
- Each memory wait cycle adds one cycle.
- `pc_en_o` is combinational and at most one cycle wide per instruction.
- The PC register updates on the edge that leaves HOLD. IDLE samples the new `pc_i` on the following cycle.
- After a flush, the first fetch uses the redirected `pc_i`: one cycle after the flush edge from REQ/HOLD, or one cycle after the drop ack from DROP.

## Configuration
- **`IFETCH_MISALIGN_CHK_EN` defined:** in IDLE, if `pc_i[1:0]!=0`, go directly to HOLD with no memory request. Load `inst_o=NOP_INST`, `inst_pc_o=pc_i`, `misalign_o=1`. HOLD then behaves as normal.
- **Not defined:** `pc_i[1:0]` is ignored (address forced word-aligned), `misalign_o` is constant 0, and no check logic is generated.

## Test plan
- **Reset and first fetch, zero-wait memory:** release reset with `pc_i=0`, ack immediately, `imem_rdata_i=32'h00500093`.
  - `imem_req_o=1`, `imem_addr_o=0` in cycle 1.
  - `have_inst_o=1`, `inst_o=32'h00500093`, `inst_pc_o=0` in cycle 2.
  - With `inst_ready_i=1`, `pc_en_o=1` for exactly one cycle.
- **Wait states:** ack 3 cycles after req, `pc_i=32'h10`.
  - `imem_req_o` is high for 3 cycles with `imem_addr_o=32'h10` throughout.
  - `have_inst_o` rises the cycle after ack.
- **Back-pressure:** hold `inst_ready_i=0` for 5 cycles in HOLD.
  - `inst_o`/`inst_pc_o` stay stable, `pc_en_o=0`, no new request.
  - Raise ready: `pc_en_o` pulses once, and the next request uses the new `pc_i`.
- **Flush while waiting:** pulse `flush_i` during REQ (`pc_i=32'h20`), then change `pc_i` to `32'h40`.
  - The request stays at `32'h20` until ack, and `have_inst_o` stays 0.
  - The next request goes to `32'h40`.
- **Flush vs ready, and reset mid-request:** `flush_i` with `inst_ready_i` in HOLD gives `pc_en_o=0` and state IDLE. Asserting `rst_i` in REQ drops `imem_req_o` asynchronously, and a later ack produces no `have_inst_o`.
- **With `IFETCH_MISALIGN_CHK_EN`:** `pc_i=32'h6` gives no `imem_req_o`, `have_inst_o=1`, `inst_o=32'h00000013`, `misalign_o=1`. Without the macro, `imem_addr_o=32'h4`.
